// File: rtl/dff_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dff_pipe_pkg
//   Shared defaults and types for the elastic register pipeline (dff_pipe).
//   Contents:
//     DEFAULT_BIT_WIDTH - default data width of one pipeline word
//     DEFAULT_DEPTH     - default number of register stages
//     pipe_word_t       - one data word at the default width
// -----------------------------------------------------------------------------
package dff_pipe_pkg;

    localparam int DEFAULT_BIT_WIDTH = 64;
    localparam int DEFAULT_DEPTH     = 4;

    typedef logic [DEFAULT_BIT_WIDTH-1:0] pipe_word_t;

endpackage : dff_pipe_pkg

// File: rtl/dff_pipe_stage.sv
// -----------------------------------------------------------------------------
// dff_pipe_stage
//   One elastic pipeline stage: a data register plus a valid flag.
//   The stage advances when it is empty or when its contents are taken
//   downstream. An empty stage therefore always accepts, so bubbles collapse.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset (clears data and valid)
//   flush_in     in   synchronous clear of the valid flag
//   take_in      in   the next stage (or the consumer) takes this stage's word
//   up_valid_in  in   valid of the word offered by the previous stage
//   up_data_in   in   data offered by the previous stage
//   adv_out      out  this stage loads from upstream on the next edge
//   valid_out    out  stage holds a valid word
//   data_out     out  stage data
// -----------------------------------------------------------------------------
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_in,
    input  logic                 take_in,
    input  logic                 up_valid_in,
    input  logic [BIT_WIDTH-1:0] up_data_in,
    output logic                 adv_out,
    output logic                 valid_out,
    output logic [BIT_WIDTH-1:0] data_out
);

    logic                 valid_q, valid_d;
    logic [BIT_WIDTH-1:0] data_q,  data_d;

    assign adv_out = !valid_q || take_in;

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv_out) begin
            valid_d = up_valid_in;
            // Data only moves with a valid word, so idle stages do not toggle.
            if (up_valid_in) begin
                data_d = up_data_in;
            end
        end
        // Flush outranks any advance; data contents are don't-care once invalid.
        if (flush_in) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples the
    // pre-edge values regardless of process evaluation order.
    // NOTE: the data register is reset as well as the valid flag because the
    // output word must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule : dff_pipe_stage

// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe
//   Parametrised elastic register pipeline with valid/ready handshake,
//   bubble collapsing, synchronous flush and a registered occupancy count.
// Ports:
//   clk        in   rising-edge clock
//   rst_n_in   in   asynchronous active-low reset
//   d_in       in   upstream data
//   valid_in   in   upstream data valid
//   ready_out  out  pipeline accepts d_in this cycle
//   q_output   out  data of the last stage
//   valid_out  out  last stage holds valid data
//   ready_in   in   downstream accepts q_output this cycle
//   flush_in   in   synchronous clear of all stage valids
//   count_out  out  number of valid stages, 0..DEPTH
// -----------------------------------------------------------------------------
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter  int BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter  int DEPTH     = DEFAULT_DEPTH,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n_in,
    input  logic [BIT_WIDTH-1:0] d_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [BIT_WIDTH-1:0] q_output,
    output logic                 valid_out,
    input  logic                 ready_in,
    input  logic                 flush_in,
    output logic [CNT_W-1:0]     count_out
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dff_pipe: DEPTH must be at least 1");
    end

    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] count_q, count_d;

    // The ready chain is purely combinational from ready_in back to stage 0:
    // each stage advances if it is empty or the stage after it advances.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic                 adv;
        logic                 take;
        logic                 up_valid;
        logic [BIT_WIDTH-1:0] up_data;
        logic                 v;
        logic [BIT_WIDTH-1:0] data;

        if (i == DEPTH - 1) begin : g_last
            assign take = ready_in;
        end else begin : g_inner
            assign take = g_stage[i+1].adv;
        end

        if (i == 0) begin : g_first
            assign up_valid = in_xfer;
            assign up_data  = d_in;
        end else begin : g_chain
            assign up_valid = g_stage[i-1].v;
            assign up_data  = g_stage[i-1].data;
        end

        dff_pipe_stage #(
            .BIT_WIDTH (BIT_WIDTH)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n_in),
            .flush_in    (flush_in),
            .take_in     (take),
            .up_valid_in (up_valid),
            .up_data_in  (up_data),
            .adv_out     (adv),
            .valid_out   (v),
            .data_out    (data)
        );
    end

    // Input is refused during a flush so the offered word cannot slip past it.
    assign ready_out = g_stage[0].adv && !flush_in;
    assign valid_out = g_stage[DEPTH-1].v;
    assign q_output  = g_stage[DEPTH-1].data;

    assign in_xfer  = valid_in && ready_out;
    assign out_xfer = valid_out && ready_in;

    // Simultaneous in and out leaves the count unchanged; the handshake itself
    // keeps it inside 0..DEPTH, so no saturation is needed.
    always_comb begin
        count_d = count_q;
        if (flush_in) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
        end
    end

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule : dff_pipe

// File: tb/tb_dff_pipe.sv
// -----------------------------------------------------------------------------
// tb_dff_pipe
//   Directed and randomised checks of dff_pipe at BIT_WIDTH=64, DEPTH=4.
//   Inputs change 1 ns after a rising edge; outputs are compared a further
//   1 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_dff_pipe;
    import dff_pipe_pkg::*;

    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PERIOD = 10;

    logic             clk;
    logic             rst_n_in;
    pipe_word_t       d_in;
    logic             valid_in;
    logic             ready_out;
    pipe_word_t       q_output;
    logic             valid_out;
    logic             ready_in;
    logic             flush_in;
    logic [CNT_W-1:0] count_out;

    int vectors    = 0;
    int miscompares = 0;

    dff_pipe #(
        .BIT_WIDTH (64),
        .DEPTH     (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst_n_in  (rst_n_in),
        .d_in      (d_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .q_output  (q_output),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .flush_in  (flush_in),
        .count_out (count_out)
    );

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    initial begin
        #(PERIOD * 50000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs, let combinational outputs settle.
    task automatic drive(input logic v, input pipe_word_t d, input logic rdy, input logic fl);
        valid_in = v;
        d_in     = d;
        ready_in = rdy;
        flush_in = fl;
        #1;
    endtask

    pipe_word_t sb[$];
    logic       pending;
    logic       exp_rdy;

    initial begin
        rst_n_in = 1'b0;
        d_in     = '0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        flush_in = 1'b0;

        // ---- reset state ----
        #12;
        chk("reset valid_out", 64'(valid_out), 64'd0);
        chk("reset q_output", q_output, 64'd0);
        chk("reset count_out", 64'(count_out), 64'd0);
        chk("reset ready_out", 64'(ready_out), 64'd1);
        rst_n_in = 1'b1;
        tick();

        // ---- unstalled stream: 87,2,68 ----
        drive(1'b1, 64'd87, 1'b1, 1'b0); tick();
        chk("s2 count e1", 64'(count_out), 64'd1);
        drive(1'b1, 64'd2, 1'b1, 1'b0); tick();
        chk("s2 count e2", 64'(count_out), 64'd2);
        drive(1'b1, 64'd68, 1'b1, 1'b0); tick();
        chk("s2 count e3", 64'(count_out), 64'd3);
        chk("s2 no early valid", 64'(valid_out), 64'd0);
        drive(1'b0, 64'd0, 1'b1, 1'b0); tick();
        chk("s2 valid e4", 64'(valid_out), 64'd1);
        chk("s2 q e4", q_output, 64'd87);
        chk("s2 count e4", 64'(count_out), 64'd3);
        tick();
        chk("s2 q e5", q_output, 64'd2);
        chk("s2 count e5", 64'(count_out), 64'd2);
        tick();
        chk("s2 q e6", q_output, 64'd68);
        chk("s2 count e6", 64'(count_out), 64'd1);
        tick();
        chk("s2 drained valid", 64'(valid_out), 64'd0);
        chk("s2 drained count", 64'(count_out), 64'd0);

        // ---- backpressure: 87,2,68,5 fill, 9 held ----
        drive(1'b1, 64'd87, 1'b0, 1'b0); chk("s3 rdy 87", 64'(ready_out), 64'd1); tick();
        drive(1'b1, 64'd2,  1'b0, 1'b0); chk("s3 rdy 2",  64'(ready_out), 64'd1); tick();
        drive(1'b1, 64'd68, 1'b0, 1'b0); chk("s3 rdy 68", 64'(ready_out), 64'd1); tick();
        drive(1'b1, 64'd5,  1'b0, 1'b0); chk("s3 rdy 5",  64'(ready_out), 64'd1); tick();
        drive(1'b1, 64'd9,  1'b0, 1'b0);
        chk("s3 full ready_out", 64'(ready_out), 64'd0);
        chk("s3 full count", 64'(count_out), 64'd4);
        chk("s3 full q", q_output, 64'd87);
        tick();
        chk("s3 stall q", q_output, 64'd87);
        chk("s3 stall valid", 64'(valid_out), 64'd1);
        chk("s3 stall count", 64'(count_out), 64'd4);
        chk("s3 stall ready_out", 64'(ready_out), 64'd0);
        drive(1'b1, 64'd9, 1'b1, 1'b0);
        chk("s3 full+ready ready_out", 64'(ready_out), 64'd1);
        tick();
        chk("s3 q 2", q_output, 64'd2);
        chk("s3 count in+out", 64'(count_out), 64'd4);
        drive(1'b0, 64'd0, 1'b1, 1'b0); tick();
        chk("s3 q 68", q_output, 64'd68);
        chk("s3 count 3", 64'(count_out), 64'd3);
        tick();
        chk("s3 q 5", q_output, 64'd5);
        tick();
        chk("s3 q 9", q_output, 64'd9);
        chk("s3 valid 9", 64'(valid_out), 64'd1);
        tick();
        chk("s3 drained valid", 64'(valid_out), 64'd0);
        chk("s3 drained count", 64'(count_out), 64'd0);

        // ---- bubble collapse: valid 1,0,1 under stall ----
        drive(1'b1, 64'd87, 1'b0, 1'b0); tick();
        drive(1'b0, 64'd0,  1'b0, 1'b0); tick();
        drive(1'b1, 64'd2,  1'b0, 1'b0); tick();
        drive(1'b0, 64'd0,  1'b0, 1'b0); tick(); tick();
        chk("s4 count", 64'(count_out), 64'd2);
        chk("s4 q", q_output, 64'd87);
        chk("s4 ready_out", 64'(ready_out), 64'd1);
        drive(1'b0, 64'd0, 1'b1, 1'b0); tick();
        chk("s4 q 2 adjacent", q_output, 64'd2);
        chk("s4 valid 2", 64'(valid_out), 64'd1);
        tick();
        chk("s4 drained", 64'(valid_out), 64'd0);

        // ---- flush of a full pipe with a word offered ----
        drive(1'b1, 64'd11, 1'b0, 1'b0); tick();
        drive(1'b1, 64'd22, 1'b0, 1'b0); tick();
        drive(1'b1, 64'd33, 1'b0, 1'b0); tick();
        drive(1'b1, 64'd44, 1'b0, 1'b0); tick();
        drive(1'b1, 64'd55, 1'b0, 1'b1);
        chk("s5 flush ready_out", 64'(ready_out), 64'd0);
        tick();
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        chk("s5 flush count", 64'(count_out), 64'd0);
        chk("s5 flush valid", 64'(valid_out), 64'd0);
        tick(); tick(); tick(); tick(); tick();
        chk("s5 dropped word", 64'(valid_out), 64'd0);
        chk("s5 count after", 64'(count_out), 64'd0);

        // ---- asynchronous reset mid-cycle with a full pipe ----
        drive(1'b1, 64'd71, 1'b0, 1'b0); tick();
        drive(1'b1, 64'd72, 1'b0, 1'b0); tick();
        drive(1'b1, 64'd73, 1'b0, 1'b0); tick();
        drive(1'b1, 64'd74, 1'b0, 1'b0); tick();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        chk("s1 pre count", 64'(count_out), 64'd4);
        rst_n_in = 1'b0;
        #1;
        chk("s1 async valid", 64'(valid_out), 64'd0);
        chk("s1 async q", q_output, 64'd0);
        chk("s1 async count", 64'(count_out), 64'd0);
        chk("s1 async ready", 64'(ready_out), 64'd1);
        rst_n_in = 1'b1;
        tick();

        // ---- random traffic against a queue model ----
        pending = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!pending) begin
                valid_in = ($urandom_range(0, 3) != 0);
                d_in     = {$urandom, $urandom};
            end
            ready_in = ($urandom_range(0, 2) != 0);
            flush_in = ($urandom_range(0, 99) == 0);
            #1;
            exp_rdy = !flush_in && !(sb.size() == DEPTH && !ready_in);
            chk("rnd ready_out", 64'(ready_out), 64'(exp_rdy));
            chk("rnd count", 64'(count_out), 64'(sb.size()));
            if (valid_out) begin
                chk("rnd nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) chk("rnd q order", q_output, sb[0]);
            end
            if (valid_out && ready_in && sb.size() != 0) void'(sb.pop_front());
            if (flush_in) sb.delete();
            else if (valid_in && exp_rdy) sb.push_back(d_in);
            pending = valid_in && !exp_rdy;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dff_pipe
